// File: rtl/ddc_edid_responder_pkg.sv
// ddc_pkg: shared state encoding and constants for the DDC EDID responder.
package ddc_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, OFFSET, OFFSET_ACK, WDATA, TX, MACK} state_t;
    localparam logic [6:0]  DEFAULT_DEVICE_ADDR = 7'h50;
    localparam logic [63:0] EDID_HEADER         = 64'h00FF_FFFF_FFFF_FF00;
endpackage

// File: rtl/ddc_edid_responder_if.sv
// ddc_if: DDC pad signals in IOBUF i/o/t form; slave is the responder, master the pad side.
interface ddc_if;
    logic scl_i, scl_o, scl_t;
    logic sda_i, sda_o, sda_t;
    modport slave  (input scl_i, sda_i, output scl_o, scl_t, sda_o, sda_t);
    modport master (output scl_i, sda_i, input scl_o, scl_t, sda_o, sda_t);
endinterface

// File: rtl/ddc_edid_responder_line_filter.sv
// ddc_line_filter: synchroniser plus glitch filter for one I2C line, with edge pulses on the filtered level.
module ddc_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level, r_prev;
    logic                   w_s;
    assign w_s = r_sync[SYNC_STAGES-1];
    // r_cnt counts consecutive samples that disagree with the filtered level
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sync  <= '1;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync <= SYNC_STAGES'({r_sync, i_line});
            r_prev <= r_level;
            if (w_s == r_level) r_cnt <= '0;
            else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else r_cnt <= r_cnt + 1'b1;
        end
    end
    assign o_level = r_level;
    assign o_rise  = r_level & ~r_prev;
    assign o_fall  = ~r_level & r_prev;
endmodule

// File: rtl/ddc_edid_responder.sv
// ddc_edid_responder: I2C/DDC target answering EDID reads from a host-loaded RAM.
module ddc_edid_responder
    import ddc_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = DEFAULT_DEVICE_ADDR,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3,
    parameter int         ADDR_W      = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    ddc_if.slave              ddc,
    input  logic              edid_we,
    input  logic [ADDR_W-1:0] edid_waddr,
    input  logic [7:0]        edid_wdata,
    output logic              busy,
    output logic              rd_done
);
    logic              w_scl, w_scl_rise, w_scl_fall, w_sda, w_sda_rise, w_sda_fall;
    logic              w_start, w_stop, w_byte_end;
    logic [7:0]        w_byte;
    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic [7:0]        r_shift, r_rdata;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_sda_t, r_rw, r_rd_seen, r_rd_done;
    logic [7:0]        r_mem [2**ADDR_W];

    ddc_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
        .aclk(aclk), .aresetn(aresetn), .i_line(ddc.scl_i),
        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall));
    ddc_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
        .aclk(aclk), .aresetn(aresetn), .i_line(ddc.sda_i),
        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall));

    assign w_start    = w_sda_fall & w_scl;
    assign w_stop     = w_sda_rise & w_scl;
    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_byte_end = w_scl_rise && r_cnt == 4'd7;

    // r_rdata continuously tracks RAM[pointer] so a byte is ready before its first falling edge
    always_ff @(posedge aclk) begin
        if (edid_we) r_mem[edid_waddr] <= edid_wdata;
        r_rdata <= r_mem[r_ptr];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ADDR:       if (w_byte_end) w_next = (w_byte[7:1] == DEVICE_ADDR) ? ADDR_ACK : IDLE;
            ADDR_ACK:   if (w_scl_fall && !r_sda_t) w_next = r_rw ? TX : OFFSET;
            OFFSET:     if (w_byte_end) w_next = OFFSET_ACK;
            OFFSET_ACK: if (w_scl_fall && !r_sda_t) w_next = WDATA;
            TX:         if (w_scl_fall && r_cnt == 4'd8) w_next = MACK;
            MACK:       if (w_scl_rise) w_next = w_sda ? IDLE : TX;
            default:    w_next = r_state;
        endcase
        if (w_start) w_next = ADDR;
        else if (w_stop) w_next = IDLE;
    end

    // In the ACK states r_sda_t doubles as the phase flag: high before the drive, low during it
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_sda_t   <= 1'b1;
            r_rw      <= 1'b0;
            r_rd_seen <= 1'b0;
            r_rd_done <= 1'b0;
        end else begin
            r_rd_done <= w_stop & r_rd_seen;
            if (w_start || w_stop) begin
                r_cnt   <= '0;
                r_sda_t <= 1'b1;
                if (w_stop) r_rd_seen <= 1'b0;
            end else begin
                case (r_state)
                    ADDR, OFFSET: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == 4'd7) begin
                            r_cnt <= '0;
                            if (r_state == ADDR) r_rw <= w_sda;
                            else r_ptr <= ADDR_W'(w_byte);
                        end
                    end
                    ADDR_ACK, OFFSET_ACK: if (w_scl_fall) begin
                        r_sda_t <= !r_sda_t;
                        r_cnt   <= '0;
                        if (!r_sda_t && r_state == ADDR_ACK && r_rw) begin
                            r_sda_t   <= r_rdata[7];
                            r_shift   <= {r_rdata[6:0], 1'b0};
                            r_cnt     <= 4'd1;
                            r_rd_seen <= 1'b1;
                        end
                    end
                    TX: if (w_scl_fall) begin
                        r_sda_t <= (r_cnt == 4'd8) ? 1'b1 : r_shift[7];
                        r_shift <= {r_shift[6:0], 1'b0};
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == 4'd8) r_ptr <= r_ptr + 1'b1;
                    end
                    MACK: if (w_scl_rise && !w_sda) begin
                        r_shift <= r_rdata;
                        r_cnt   <= '0;
                    end
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    always_comb begin
        busy      = !(r_state inside {IDLE, ADDR});
        rd_done   = r_rd_done;
        ddc.sda_t = r_sda_t;
        ddc.sda_o = 1'b0;
        ddc.scl_o = 1'b0;
        ddc.scl_t = 1'b1;
    end
endmodule

// File: doc/ddc_edid_responder.md
Name: ddc_edid_responder

Overview:
- I2C/DDC target (responder) for the HDMI-input DDC channel. It answers an HDMI source's EDID reads at 7-bit address 0x50 from a 256-byte EDID RAM.
- The processor loads the RAM through a simple write port.
- It is the counterpart of the DDC initiator that serves HDMI-out. It connects to the top-level IOBUF signals in i/o/t form.

Parameters:
- DEVICE_ADDR, 7'h50, 7-bit I2C address the block answers.
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i.
- FILTER_LEN, 3, consecutive equal samples required before a filtered line changes.
- ADDR_W, 8, EDID RAM address width (depth 2**ADDR_W).

Ports:
- aclk  in  1  system clock, 100 MHz nominal.
- aresetn  in  1  asynchronous active-low reset.
- scl_i  in  1  DDC SCL from IOBUF.
- scl_o  out  1  tied 0.
- scl_t  out  1  tied 1; no clock stretching.
- sda_i  in  1  DDC SDA from IOBUF.
- sda_o  out  1  tied 0.
- sda_t  out  1  1 = release, 0 = pull low.
- edid_we  in  1  host write strobe.
- edid_waddr  in  ADDR_W  host write address.
- edid_wdata  in  8  host write data.
- busy  out  1  high from address-match ACK until STOP, NACK or mismatch.
- rd_done  out  1  one-cycle pulse on STOP that ends a transaction containing at least one read byte.

Behaviour:
- Reset: asynchronous, aresetn low.
  - sda_t=1, busy=0, rd_done=0, state IDLE, pointer=0, filtered lines=1.
  - RAM contents are not reset.
  - Reset mid-transfer releases SDA in the same cycle.
- Line conditioning:
  - SYNC_STAGES flops, then a glitch filter. The filtered value toggles only after FILTER_LEN identical consecutive samples.
  - Edges are detected on the filtered lines.
- Bus conditions:
  - START = filtered SDA falls while filtered SCL is high.
  - STOP = filtered SDA rises while filtered SCL is high.
  - Both are recognised in every state, including mid-byte and during our own drive. They take priority over bit handling in the same cycle.
  - On START: go to ADDR, bit counter cleared, sda_t=1 next cycle.
  - On STOP: go to IDLE, sda_t=1 next cycle, pulse rd_done if applicable.
- Bit timing:
  - Sample SDA on the filtered SCL rising edge.
  - Change sda_t only on the filtered SCL falling edge.
- State machine:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits MSB first.
    - {addr[6:0],rw} != {DEVICE_ADDR,x}: go to IDLE, never drive.
    - Match: go to ADDR_ACK.
  - ADDR_ACK: drive sda_t=0 from the falling edge after bit 8 until the next falling edge.
    - rw=0: go to OFFSET.
    - rw=1: load RAM[pointer] into the shift register and go to TX.
  - OFFSET: shift 8 bits, pointer <= byte, then OFFSET_ACK (ACK drive as above), then WDATA.
  - WDATA: further write bytes are NACKed (sda_t stays 1) and discarded. The pointer is unchanged. Stay in WDATA until START/STOP.
  - TX: on each falling edge, sda_t = current bit (release for 1, drive for 0), MSB first.
    - After 8 bits, release on the 8th-bit-ending falling edge and go to MACK.
    - pointer <= pointer+1 when the 8th bit is released; it wraps 2**ADDR_W-1 to 0.
  - MACK: sample the master's bit on the 9th rising edge.
    - 0 (ACK): load RAM[pointer], go to TX.
    - 1 (NACK): go to IDLE, no further drive.
- Pointer persistence: the pointer persists across transactions, so a read without a preceding offset write is a current-address read.
- RAM:
  - Single write port plus one synchronous read port used by the load.
  - A host write on the same cycle as a load of the same address delivers the old data.
  - A host write lands one cycle after edid_we.
- Latency: SDA reacts SYNC_STAGES+FILTER_LEN+1 cycles after a physical SCL falling edge. The design requires SCL low time ≥ 20 aclk cycles (met at 100 kHz and 400 kHz).

Decomposition:
- Package ddc_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, OFFSET, OFFSET_ACK, WDATA, TX, MACK);
  - DEFAULT_DEVICE_ADDR = 7'h50;
  - EDID_HEADER constant (00 FF FF FF FF FF FF 00).
- Sub-module ddc_line_filter: synchroniser, glitch filter and rise/fall pulses. Instantiated once for SCL and once for SDA.

Test Plan:
- Random-access read: host loads the EDID header at 0x00–0x07 and mem[i]=i elsewhere. Master sends START, 0xA0, 0x00, Sr, 0xA1, reads 8 bytes ACK×7 then NACK, STOP.
  - Three ACKs observed.
  - Bytes 00 FF FF FF FF FF FF 00.
  - rd_done pulses once.
  - busy low after STOP.
- Address mismatch: START, 0xA4, then 2 bytes.
  - sda_t stays 1 throughout.
  - busy stays 0.
- Pointer wrap: offset 0xFE, read 4 bytes.
  - Returns mem[FE], mem[FF], mem[00]=0x00, mem[01]=0xFF.
  - Pointer ends at 0x02.
- Current-address read: a following START, 0xA1, 1 byte, NACK returns mem[02]=0xFF.
- Extra write byte: START, 0xA0, 0x10, then data byte 0x55.
  - Third byte is NACKed.
  - mem[0x10] unchanged.
  - Pointer = 0x10.
- Robustness:
  - STOP injected after bit 3 of a TX byte: sda_t=1 within 1 cycle of the detected STOP, state IDLE.
  - 1-cycle SCL glitch with FILTER_LEN=3: no extra bit shifted.
  - aresetn low mid-TX: sda_t=1 immediately, pointer=0.
